init: RTL and testbench

INIT -- requirements
Module: init

---
 rtl/init.sv | 66 ++++++
 tb/tb_init.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/init.sv
// ARC4 S-array init: writes mem[i]=i for i=0..255; define INIT_RESTART_EN to let en restart an active fill.
// Latency: the write to addr 0 is presented from the accepting edge; 256 back-to-back writes; rdy returns one edge after addr 255.
// Backpressure: none downstream; en is taken only while rdy=1, or during a fill when INIT_RESTART_EN is defined.
module init (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] addr,
    output logic [7:0] wrdata,
    output logic       wren
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = 8'd0;
                if (en) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                // The 8-bit increment wraps 255 -> 0, leaving cnt at 0 for IDLE.
                cnt_next = cnt + 8'd1;
                if (cnt == 8'd255) begin
                    state_next = IDLE;
                end
`ifdef INIT_RESTART_EN
                if (en) begin
                    state_next = FILL;
                    cnt_next   = 8'd0;
                end
`endif
            end
        endcase
    end

    // Outputs decode straight from the state and counter flops; en never reaches them combinationally.
    assign rdy    = (state == IDLE);
    assign wren   = (state == FILL);
    assign addr   = cnt;
    assign wrdata = cnt;

endmodule

// File: tb/tb_init.sv
// Self-checking bench for init: vector table for reset/handshake, scoreboard of expected writes, corner-case sequences.
module tb_init;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic       wren;
    logic [7:0] addr;
    logic [7:0] wrdata;

    always #5 clk = ~clk;

    init dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .addr   (addr),
        .wrdata (wrdata),
        .wren   (wren)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem[256];
    logic [7:0] exp_wr;
    int         run      = 0;
    int         last_run = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       push;
        logic       exp_rdy;
        logic       exp_wren;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_fill();
        for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    endtask

    task automatic init_mem();
        for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
    endtask

    task automatic check_mem();
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 8'(i)) bad++;
        check("mem_identity_bad_locations", bad, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdy"}, rdy, 1);
        check({tag, "_wren"}, wren, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_wrdata"}, wrdata, 0);
    endtask

    // Returns the number of rising edges until rdy is seen high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 400);
        if (!rdy) check("idle_timeout", 0, 1);
    endtask

    task automatic finish_fill(input int exp_edges, input int exp_run);
        int n;
        wait_idle(n);
        check("edges_to_idle", n, exp_edges);
        @(negedge clk);
        #1;
        check("rdy_low_cycles", last_run, exp_run);
        check("scoreboard_empty", exp_q.size(), 0);
        check_idle_outputs("post_fill");
    endtask

    task automatic start_fill();
        en = 1'b1;
        push_fill();
        @(posedge clk);
        #1;
        en = 1'b0;
        check("start_rdy", rdy, 0);
        check("start_addr", addr, 0);
    endtask

    task automatic wait_addr(input logic [7:0] target);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (addr != target && n < 300);
        check("reach_addr", addr, target);
    endtask

    // Scoreboard: every write observed must match the next expected address/data.
    always @(negedge clk) begin
        if (wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", addr, 32'hffff_ffff);
            end else begin
                exp_wr = exp_q.pop_front();
                check("wr_addr", addr, exp_wr);
                check("wr_data", wrdata, exp_wr);
                mem[addr] = wrdata;
            end
        end
        if (rdy !== 1'b1) begin
            run++;
        end else if (run != 0) begin
            last_run = run;
            run      = 0;
        end
    end

    initial begin
        int lowrun;
        int highs;
        int n;

        rst_n = 1'b0;
        en    = 1'b0;
        init_mem();

        vecs[0] = '{rst_n: 1'b0, en: 1'b1, push: 1'b0, exp_rdy: 1'b1, exp_wren: 1'b0, exp_addr: 8'd0};
        vecs[1] = '{rst_n: 1'b1, en: 1'b1, push: 1'b1, exp_rdy: 1'b0, exp_wren: 1'b1, exp_addr: 8'd0};
        vecs[2] = '{rst_n: 1'b1, en: 1'b1, push: 1'b0, exp_rdy: 1'b0, exp_wren: 1'b1, exp_addr: 8'd1};
        vecs[3] = '{rst_n: 1'b1, en: 1'b1, push: 1'b0, exp_rdy: 1'b0, exp_wren: 1'b1, exp_addr: 8'd2};
        vecs[4] = '{rst_n: 1'b1, en: 1'b1, push: 1'b0, exp_rdy: 1'b0, exp_wren: 1'b1, exp_addr: 8'd3};
        vecs[5] = '{rst_n: 1'b1, en: 1'b0, push: 1'b0, exp_rdy: 1'b0, exp_wren: 1'b1, exp_addr: 8'd4};

        // Reset state before any clock edge.
        #3;
        check_idle_outputs("reset");

        // Reset release, en held 4 cycles from release: one fill only.
        for (int i = 0; i < 6; i++) begin
            rst_n = vecs[i].rst_n;
            en    = vecs[i].en;
            if (vecs[i].push) push_fill();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rdy", i), rdy, vecs[i].exp_rdy);
            check($sformatf("vec%0d_wren", i), wren, vecs[i].exp_wren);
            check($sformatf("vec%0d_addr", i), addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_wrdata", i), wrdata, vecs[i].exp_addr);
        end
        finish_fill(252, 256);
        check_mem();

        // Second identical fill after a long idle gap.
        init_mem();
        repeat (260) @(posedge clk);
        #1;
        check_idle_outputs("long_idle");
        start_fill();
        finish_fill(256, 256);
        check_mem();

        // Asynchronous reset mid-fill, then a clean restart.
        start_fill();
        wait_addr(8'd100);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_abort");
        check("abort_unwritten", exp_q.size(), 156);
        exp_q.delete();
        @(posedge clk);
        #1;
        check_idle_outputs("held_reset");
        rst_n = 1'b1;
        init_mem();
        start_fill();
        finish_fill(256, 256);
        check_mem();

        // en held constantly: 256-write bursts separated by exactly one idle cycle.
        lowrun = 0;
        highs  = 0;
        en     = 1'b1;
        for (int c = 0; c < 771; c++) begin
            if (rdy) push_fill();
            @(posedge clk);
            #1;
            if (rdy) begin
                highs++;
                check("held_en_burst_len", lowrun, 256);
                lowrun = 0;
            end else begin
                lowrun++;
            end
        end
        en = 1'b0;
        check("held_en_idle_gaps", highs, 3);
        @(negedge clk);
        #1;
        check("held_en_scoreboard_empty", exp_q.size(), 0);

        // en pulsed mid-fill at addr 50.
        start_fill();
        wait_addr(8'd50);
        @(negedge clk);
        #1;
        en = 1'b1;
`ifdef INIT_RESTART_EN
        exp_q.delete();
        push_fill();
        @(posedge clk);
        #1;
        en = 1'b0;
        check("restart_addr", addr, 0);
        check("restart_wren", wren, 1);
        finish_fill(256, 307);
`else
        @(posedge clk);
        #1;
        en = 1'b0;
        check("ignored_en_addr", addr, 51);
        check("ignored_en_rdy", rdy, 0);
        finish_fill(205, 256);
`endif
        check_mem();

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
